// File: rtl/jtframe_sdram_arb_if.sv
// jtframe_sdram_arb_if: ROM requester slots and the shared SDRAM read port.
// The master modport is the arbiter side. The slave modport is the requesters plus the controller.
interface jtframe_sdram_arb_if #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
);
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [DW-1:0]       slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic [DW-1:0]       data_read;
    logic                data_rdy;
    logic                loop_rst;
    logic                busy;

    modport master (
        input  slot_req, slot_addr, sdram_ack, data_read, data_rdy, loop_rst,
        output slot_ok, slot_dout, sdram_req, sdram_addr, busy
    );
    modport slave (
        output slot_req, slot_addr, sdram_ack, data_read, data_rdy, loop_rst,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, busy
    );
endinterface

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: round-robin arbiter for SLOTS ROM requesters over one SDRAM read port.
// Defining JTFRAME_SDRAM_PRIO_EN switches to fixed priority, where the lowest index wins.
module jtframe_sdram_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input logic clk_rom,
    input logic rst,
    jtframe_sdram_arb_if.master bus
);
    localparam int GW = $clog2(SLOTS);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] grant, last, pick;
    logic          done;

    always_comb begin
        pick = '0;
`ifdef JTFRAME_SDRAM_PRIO_EN
        for (int k = SLOTS-1; k >= 0; k--)
            if (bus.slot_req[k]) pick = GW'(k);
`else
        // Scan from the farthest slot down, so the nearest requester after last wins.
        for (int k = SLOTS; k >= 1; k--)
            if (bus.slot_req[(int'(last)+k)%SLOTS]) pick = GW'((int'(last)+k)%SLOTS);
`endif
        done = (state == REQ && bus.sdram_ack && bus.data_rdy) || (state == WAIT && bus.data_rdy);
    end

    assign bus.busy = state != IDLE;

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state          <= IDLE;
            grant          <= '0;
            last           <= GW'(SLOTS-1);
            bus.slot_ok    <= '0;
            bus.slot_dout  <= '0;
            bus.sdram_req  <= 1'b0;
            bus.sdram_addr <= '0;
        end else begin
            bus.slot_ok <= '0;
            if (bus.loop_rst) begin
                state         <= IDLE;
                bus.sdram_req <= 1'b0;
            end else if (state == IDLE) begin
                if (|bus.slot_req) begin
                    grant          <= pick;
                    bus.sdram_addr <= bus.slot_addr[int'(pick)*AW +: AW];
                    bus.sdram_req  <= 1'b1;
                    state          <= REQ;
                end
            end else if (done) begin
                // A requester that withdrew still gets its data on the bus, but no strobe.
                bus.slot_dout        <= bus.data_read;
                bus.slot_ok[grant]   <= bus.slot_req[grant];
                last                 <= grant;
                bus.sdram_req        <= 1'b0;
                state                <= IDLE;
            end else if (state == REQ && bus.sdram_ack) begin
                bus.sdram_req <= 1'b0;
                state         <= WAIT;
            end else if (state != REQ && state != WAIT) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb_jtframe_sdram_arb: directed checks of grant order, completion strobe, loop_rst and rst aborts.
module tb_jtframe_sdram_arb;
    localparam int SLOTS = 4, AW = 22, DW = 32;
    localparam logic [AW-1:0] A0 = 22'h0A000, A1 = 22'h1B111, A2 = 22'h12345, A3 = 22'h3D333;

    logic clk_rom = 1'b0;
    logic rst = 1'b1;
    int   checks = 0, failures = 0;

    jtframe_sdram_arb_if #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) bus ();

    jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk_rom(clk_rom),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_rom = ~clk_rom;

    task automatic cyc();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int s);
        return s == 0 ? A0 : s == 1 ? A1 : s == 2 ? A2 : A3;
    endfunction

    initial begin
        bus.slot_req  = '0;
        bus.slot_addr = {A3, A2, A1, A0};
        bus.sdram_ack = 1'b0;
        bus.data_read = '0;
        bus.data_rdy  = 1'b0;
        bus.loop_rst  = 1'b0;
        cyc();
        cyc();
        chk("rst_slot_ok", 64'(bus.slot_ok), 64'h0);
        chk("rst_slot_dout", 64'(bus.slot_dout), 64'h0);
        chk("rst_sdram_req", 64'(bus.sdram_req), 64'h0);
        chk("rst_sdram_addr", 64'(bus.sdram_addr), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        rst = 1'b0;
        // Stray ack/data while idle must be ignored.
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h99999999;
        cyc();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        chk("idle_ack_busy", 64'(bus.busy), 64'h0);
        chk("idle_rdy_dout", 64'(bus.slot_dout), 64'h0);
        chk("idle_rdy_ok", 64'(bus.slot_ok), 64'h0);

        // Single request from slot 2
        bus.slot_req = 4'b0100;
        chk("t1_req_not_yet", 64'(bus.sdram_req), 64'h0);
        cyc();
        chk("t1_sdram_req", 64'(bus.sdram_req), 64'h1);
        chk("t1_sdram_addr", 64'(bus.sdram_addr), 64'h12345);
        chk("t1_busy", 64'(bus.busy), 64'h1);
        bus.slot_addr[2*AW +: AW] = 22'h00777;
        cyc();
        chk("t1_addr_latched", 64'(bus.sdram_addr), 64'h12345);
        chk("t1_req_held", 64'(bus.sdram_req), 64'h1);
        bus.slot_addr[2*AW +: AW] = A2;
        bus.sdram_ack = 1'b1;
        cyc();
        bus.sdram_ack = 1'b0;
        chk("t1_req_cleared", 64'(bus.sdram_req), 64'h0);
        chk("t1_wait_busy", 64'(bus.busy), 64'h1);
        cyc();
        cyc();
        chk("t1_no_early_ok", 64'(bus.slot_ok), 64'h0);
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'hDEADBEEF;
        cyc();
        bus.data_rdy = 1'b0;
        chk("t1_slot_ok", 64'(bus.slot_ok), 64'h4);
        chk("t1_slot_dout", 64'(bus.slot_dout), 64'hDEADBEEF);
        chk("t1_done_busy", 64'(bus.busy), 64'h0);
        bus.slot_req = 4'b0000;
        cyc();
        chk("t1_ok_one_cycle", 64'(bus.slot_ok), 64'h0);
        chk("t1_dout_kept", 64'(bus.slot_dout), 64'hDEADBEEF);
        chk("t1_no_regrant", 64'(bus.sdram_req), 64'h0);

        // All four slots requesting after reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.slot_req = 4'b1111;
        cyc();
        chk("rr_first_req", 64'(bus.sdram_req), 64'h1);
        for (int n = 0; n < 5; n++) begin
`ifdef JTFRAME_SDRAM_PRIO_EN
            automatic int g = 0;
`else
            automatic int g = n % SLOTS;
`endif
            chk($sformatf("rr_addr_%0d", n), 64'(bus.sdram_addr), 64'(addr_of(g)));
            bus.sdram_ack = 1'b1;
            cyc();
            bus.sdram_ack = 1'b0;
            chk($sformatf("rr_req_low_%0d", n), 64'(bus.sdram_req), 64'h0);
            bus.data_rdy  = 1'b1;
            bus.data_read = 32'hA0A00000 + 32'(n);
            cyc();
            bus.data_rdy = 1'b0;
            chk($sformatf("rr_ok_%0d", n), 64'(bus.slot_ok), 64'(4'b0001 << g));
            chk($sformatf("rr_dout_%0d", n), 64'(bus.slot_dout), 64'(32'hA0A00000 + 32'(n)));
            chk($sformatf("rr_gap_%0d", n), 64'(bus.sdram_req), 64'h0);
            if (n == 4) bus.slot_req = 4'b0000;
            cyc();
            chk($sformatf("rr_ok_clear_%0d", n), 64'(bus.slot_ok), 64'h0);
            chk($sformatf("rr_next_req_%0d", n), 64'(bus.sdram_req), n == 4 ? 64'h0 : 64'h1);
        end

        // ack and data_rdy in the same cycle
        bus.slot_req = 4'b0010;
        cyc();
        chk("t3_addr", 64'(bus.sdram_addr), 64'(A1));
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'hCAFEF00D;
        cyc();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        chk("t3_ok", 64'(bus.slot_ok), 64'h2);
        chk("t3_dout", 64'(bus.slot_dout), 64'hCAFEF00D);
        chk("t3_busy", 64'(bus.busy), 64'h0);
        chk("t3_req", 64'(bus.sdram_req), 64'h0);
        bus.slot_req = 4'b0000;
        cyc();
        chk("t3_no_second_req", 64'(bus.sdram_req), 64'h0);
        chk("t3_ok_clear", 64'(bus.slot_ok), 64'h0);

        // loop_rst for 3 cycles while waiting for slot 1
        bus.slot_req = 4'b0010;
        cyc();
        bus.sdram_ack = 1'b1;
        cyc();
        bus.sdram_ack = 1'b0;
        chk("t4_in_wait", 64'(bus.busy), 64'h1);
        bus.loop_rst = 1'b1;
        cyc();
        chk("t4_req", 64'(bus.sdram_req), 64'h0);
        chk("t4_busy", 64'(bus.busy), 64'h0);
        chk("t4_ok", 64'(bus.slot_ok), 64'h0);
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h11111111;
        cyc();
        bus.data_rdy = 1'b0;
        chk("t4_dout_kept", 64'(bus.slot_dout), 64'hCAFEF00D);
        chk("t4_ok_held", 64'(bus.slot_ok), 64'h0);
        cyc();
        chk("t4_no_grant", 64'(bus.sdram_req), 64'h0);
        chk("t4_busy_held", 64'(bus.busy), 64'h0);
        bus.loop_rst = 1'b0;
        cyc();
        chk("t4_regrant_req", 64'(bus.sdram_req), 64'h1);
        chk("t4_regrant_addr", 64'(bus.sdram_addr), 64'(A1));
        bus.sdram_ack = 1'b1;
        cyc();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h22222222;
        cyc();
        bus.data_rdy = 1'b0;
        chk("t4_final_ok", 64'(bus.slot_ok), 64'h2);
        bus.slot_req = 4'b0000;
        cyc();

        // Slot 3 withdraws while waiting
        bus.slot_req = 4'b1000;
        cyc();
        chk("t5_addr", 64'(bus.sdram_addr), 64'(A3));
        bus.sdram_ack = 1'b1;
        cyc();
        bus.sdram_ack = 1'b0;
        bus.slot_req  = 4'b0101;
        cyc();
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h33333333;
        cyc();
        bus.data_rdy = 1'b0;
        chk("t5_ok_suppressed", 64'(bus.slot_ok), 64'h0);
        chk("t5_dout", 64'(bus.slot_dout), 64'h33333333);
        chk("t5_busy", 64'(bus.busy), 64'h0);
        cyc();
        chk("t5_next_req", 64'(bus.sdram_req), 64'h1);
        chk("t5_next_addr", 64'(bus.sdram_addr), 64'(A0));

        // rst during REQ
        bus.slot_req = 4'b0110;
        rst = 1'b1;
        cyc();
        chk("t6_req", 64'(bus.sdram_req), 64'h0);
        chk("t6_addr", 64'(bus.sdram_addr), 64'h0);
        chk("t6_dout", 64'(bus.slot_dout), 64'h0);
        chk("t6_ok", 64'(bus.slot_ok), 64'h0);
        chk("t6_busy", 64'(bus.busy), 64'h0);
        rst = 1'b0;
        cyc();
        chk("t6_first_req", 64'(bus.sdram_req), 64'h1);
        chk("t6_first_addr", 64'(bus.sdram_addr), 64'(A1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
